// File: rtl/mbscore_int_pending.sv
// mbscore_int_pending
// Upstream feeder of the MBScore interrupt controller. Device IRQ lines are
// synchronised and edge-detected, then latched (or tracked, in level mode) as
// pending bits together with the on-clock syscall request. Pending bits are
// qualified by the mask and the global enable. The lowest-index eligible source
// is presented one-hot on int_vec with int_en_n low. The controller's
// acknowledge (int_jump) moves the core into service. No further request is
// raised until the handler returns (eret). A small CSR port exposes MASK,
// PENDING (write-1-to-clear), CTRL (GIE) and STATUS.
module mbscore_int_pending #(
  parameter int                N_SRC      = 7,
  parameter logic [N_SRC-1:0]  LEVEL_MODE = {N_SRC{1'b0}},
  parameter logic [N_SRC-1:0]  SYNC_EN    = {1'b0, {(N_SRC-1){1'b1}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             syscall_req,
  input  logic             int_jump,
  input  logic             eret,
  input  logic             csr_we,
  input  logic [1:0]       csr_addr,
  input  logic [N_SRC-1:0] csr_wdata,
  output logic [N_SRC-1:0] csr_rdata,
  output logic [N_SRC-1:0] int_vec,
  output logic             int_en_n,
  output logic             in_service
);

  // The top source index is the syscall; only the lower lines come from devices.
  localparam int NDEV = N_SRC - 1;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    IN_SVC   = 2'd2
  } state_t;

  // The syscall travels on syscall_req, so the matching irq_in bit is never used.
  logic unused_irq_sys;
  assign unused_irq_sys = irq_in[N_SRC-1];

  // ---------------------------------------------------------------------------
  // Input synchronisation and edge detection (device lines only)
  // ---------------------------------------------------------------------------
  logic [NDEV-1:0] sync1_q, sync2_q, prev_q;
  logic [NDEV-1:0] dev_lvl;
  logic [NDEV-1:0] dev_rise;

  // Two-flop synchroniser chain plus the previous-sample register for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq_in[NDEV-1:0];
      sync2_q <= sync1_q;
      prev_q  <= dev_lvl;
    end
  end

  // Pick the synchronised or raw level per line, then derive its rising edge.
  always_comb begin
    dev_lvl = '0;
    for (int i = 0; i < NDEV; i++) begin
      dev_lvl[i] = SYNC_EN[i] ? sync2_q[i] : irq_in[i];
    end
    dev_rise = dev_lvl & ~prev_q;
  end

  // ---------------------------------------------------------------------------
  // Pending / mask / enable state
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             gie_q, gie_d;
  logic [N_SRC-1:0] int_vec_q, int_vec_d;
  logic             int_en_n_q, int_en_n_d;
  logic             in_service_q, in_service_d;

  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] lvl_vec;
  logic [N_SRC-1:0] lvl_sel;
  logic [N_SRC-1:0] w1c_clr;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] grant;
  logic             grant_valid;
  logic             still_valid;

  // Next pending/mask/GIE: a new edge beats a same-cycle clear; level bits mirror the line.
  always_comb begin
    set_vec = {syscall_req, dev_rise};
    lvl_vec = {1'b0, dev_lvl};
    lvl_sel = {1'b0, LEVEL_MODE[NDEV-1:0]};

    w1c_clr = '0;
    if (csr_we && (csr_addr == ADDR_PENDING)) begin
      w1c_clr = csr_wdata;
    end

    ack_clr = '0;
    if ((state_q == WAIT_ACK) && int_jump) begin
      ack_clr = int_vec_q;
    end

    pending_d = (lvl_sel & lvl_vec)
              | (~lvl_sel & ((pending_q & ~(w1c_clr | ack_clr)) | set_vec));

    mask_d = mask_q;
    gie_d  = gie_q;
    if (csr_we && (csr_addr == ADDR_MASK)) begin
      mask_d = csr_wdata;
    end
    if (csr_we && (csr_addr == ADDR_CTRL)) begin
      gie_d = csr_wdata[0];
    end
  end

  // Priority encode: lowest-index eligible source wins.
  always_comb begin
    eligible    = pending_q & mask_q & {N_SRC{gie_q}};
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant       = '0;
        grant[i]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
    // A W1C on the granted bit revokes immediately; mask/GIE changes act from their register.
    still_valid = |(int_vec_q & pending_d & mask_q & {N_SRC{gie_q}});
  end

  // ---------------------------------------------------------------------------
  // Request / acknowledge FSM
  // ---------------------------------------------------------------------------
  // FSM next state and registered request outputs; the granted vector is frozen while waiting.
  always_comb begin
    state_d      = state_q;
    int_vec_d    = int_vec_q;
    int_en_n_d   = int_en_n_q;
    in_service_d = in_service_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d    = WAIT_ACK;
          int_vec_d  = grant;
          int_en_n_d = 1'b0;
        end
      end
      WAIT_ACK: begin
        if (int_jump) begin
          state_d      = IN_SVC;
          int_vec_d    = '0;
          int_en_n_d   = 1'b1;
          in_service_d = 1'b1;
        end else if (!still_valid) begin
          state_d    = IDLE;
          int_vec_d  = '0;
          int_en_n_d = 1'b1;
        end
      end
      IN_SVC: begin
        int_en_n_d = 1'b1;
        if (eret) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        int_vec_d    = '0;
        int_en_n_d   = 1'b1;
        in_service_d = 1'b0;
      end
    endcase
  end

  // Architectural state registers; reset returns everything to idle in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      mask_q       <= '0;
      gie_q        <= 1'b0;
      int_vec_q    <= '0;
      int_en_n_q   <= 1'b1;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      gie_q        <= gie_d;
      int_vec_q    <= int_vec_d;
      int_en_n_q   <= int_en_n_d;
      in_service_q <= in_service_d;
    end
  end

  // ---------------------------------------------------------------------------
  // CSR read mux and outputs
  // ---------------------------------------------------------------------------
  // Combinational read of the addressed register.
  always_comb begin
    csr_rdata = '0;
    unique case (csr_addr)
      ADDR_MASK:    csr_rdata = mask_q;
      ADDR_PENDING: csr_rdata = pending_q;
      ADDR_CTRL:    csr_rdata = {{(N_SRC-1){1'b0}}, gie_q};
      ADDR_STATUS:  csr_rdata = {{(N_SRC-3){1'b0}}, in_service_q, state_q};
      default:      csr_rdata = '0;
    endcase
  end

  assign int_vec    = int_vec_q;
  assign int_en_n   = int_en_n_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_mbscore_int_pending.sv
// Directed bench for mbscore_int_pending: a per-cycle table of inputs and
// expected registered outputs, followed by a short hand-written latency check.
module tb_mbscore_int_pending;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] irq_in;
  logic       syscall_req, int_jump, eret, csr_we;
  logic [1:0] csr_addr;
  logic [6:0] csr_wdata, csr_rdata, int_vec;
  logic       int_en_n, in_service;

  int n_cmp  = 0;
  int n_fail = 0;

  mbscore_int_pending dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .syscall_req (syscall_req),
    .int_jump    (int_jump),
    .eret        (eret),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .int_vec     (int_vec),
    .int_en_n    (int_en_n),
    .in_service  (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [6:0] irq;
    logic       sys, jmp, ert, we;
    logic [1:0] addr;
    logic [6:0] wd;
    logic [6:0] vec;
    logic       en_n;
    logic       isv;
    logic       chk;
    logic [6:0] rd;
  } step_t;

  step_t tbl[$];

  task automatic add(input logic r, input logic [6:0] irq, input logic sys,
                     input logic jmp, input logic ert, input logic we,
                     input logic [1:0] addr, input logic [6:0] wd,
                     input logic [6:0] vec, input logic en_n, input logic isv,
                     input logic chk, input logic [6:0] rd);
    step_t s;
    s.r = r; s.irq = irq; s.sys = sys; s.jmp = jmp; s.ert = ert; s.we = we;
    s.addr = addr; s.wd = wd; s.vec = vec; s.en_n = en_n; s.isv = isv;
    s.chk = chk; s.rd = rd;
    tbl.push_back(s);
  endtask

  task automatic cmp(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] irq, input logic sys,
                       input logic jmp, input logic ert, input logic we,
                       input logic [1:0] addr, input logic [6:0] wd);
    rst = r; irq_in = irq; syscall_req = sys; int_jump = jmp; eret = ert;
    csr_we = we; csr_addr = addr; csr_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    drive(1'b1, 7'h00, 0, 0, 0, 0, 2'd0, 7'h00);

    //  r  irq   sys jmp ert we addr wd     vec  en isv chk rd
    add(1, 7'h00, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h00); // 0 reset
    add(0, 7'h00, 0, 0, 0, 1, 2'd0, 7'h7F, 7'h00, 1, 0, 1, 7'h7F); // 1 mask
    add(0, 7'h00, 0, 0, 0, 1, 2'd2, 7'h01, 7'h00, 1, 0, 1, 7'h01); // 2 GIE
    add(0, 7'h04, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h00); // 3 irq2 rises
    add(0, 7'h04, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h04, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h04); // 5 pending
    add(0, 7'h04, 0, 0, 0, 0, 2'd3, 7'h00, 7'h04, 0, 0, 1, 7'h01); // 6 granted
    add(0, 7'h04, 0, 1, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h00); // 7 ack
    add(0, 7'h00, 0, 0, 0, 0, 2'd3, 7'h00, 7'h00, 1, 1, 1, 7'h06); // 8 IN_SVC
    add(0, 7'h00, 0, 0, 1, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00); // 9 eret
    add(0, 7'h00, 0, 1, 1, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00); // 10 stray ack/eret
    add(0, 7'h08, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h00); // 11 irq3 rises
    add(0, 7'h08, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h08, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h08);
    add(0, 7'h09, 0, 0, 0, 0, 2'd1, 7'h00, 7'h08, 0, 0, 1, 7'h08); // 14 irq0 rises
    add(0, 7'h09, 0, 0, 0, 0, 2'd1, 7'h00, 7'h08, 0, 0, 1, 7'h08);
    add(0, 7'h09, 0, 0, 0, 0, 2'd1, 7'h00, 7'h08, 0, 0, 1, 7'h09); // 16 frozen
    add(0, 7'h09, 0, 0, 0, 0, 2'd1, 7'h00, 7'h08, 0, 0, 1, 7'h09);
    add(0, 7'h09, 0, 1, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h01); // 18 ack irq3
    add(0, 7'h09, 0, 0, 1, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h09, 0, 0, 0, 0, 2'd3, 7'h00, 7'h01, 0, 0, 1, 7'h01); // 20 irq0 granted
    add(0, 7'h00, 0, 1, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h00);
    add(0, 7'h00, 0, 0, 1, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h00, 1, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h40); // 23 syscall
    add(0, 7'h00, 0, 0, 0, 0, 2'd1, 7'h00, 7'h40, 0, 0, 1, 7'h40);
    add(0, 7'h00, 0, 1, 0, 0, 2'd3, 7'h00, 7'h00, 1, 1, 1, 7'h06);
    add(0, 7'h02, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h00); // 26 irq1 in svc
    add(0, 7'h02, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h00);
    add(0, 7'h02, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h02);
    add(0, 7'h02, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h02); // nesting blocked
    add(0, 7'h02, 0, 0, 1, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00); // 30 eret
    add(0, 7'h02, 0, 0, 0, 0, 2'd3, 7'h00, 7'h02, 0, 0, 1, 7'h01); // 31 re-grant
    add(0, 7'h02, 0, 1, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h00);
    add(0, 7'h00, 0, 0, 1, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h00, 1, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h40); // 34 syscall
    add(0, 7'h00, 0, 0, 0, 0, 2'd1, 7'h00, 7'h40, 0, 0, 1, 7'h40);
    add(0, 7'h00, 1, 1, 0, 0, 2'd1, 7'h00, 7'h00, 1, 1, 1, 7'h40); // 36 set wins
    add(0, 7'h00, 0, 0, 1, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h40);
    add(0, 7'h00, 0, 0, 0, 0, 2'd3, 7'h00, 7'h40, 0, 0, 1, 7'h01);
    add(0, 7'h00, 0, 0, 0, 1, 2'd1, 7'h40, 7'h00, 1, 0, 1, 7'h00); // 39 W1C revoke
    add(0, 7'h00, 0, 0, 0, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h00, 0, 0, 0, 1, 2'd0, 7'h7D, 7'h00, 1, 0, 1, 7'h7D); // 41 mask bit1 off
    add(0, 7'h02, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h02, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h02, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h02); // masked pending
    add(0, 7'h02, 0, 0, 0, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h02, 0, 0, 0, 1, 2'd0, 7'h7F, 7'h00, 1, 0, 1, 7'h7F); // 46 unmask
    add(0, 7'h02, 0, 0, 0, 0, 2'd3, 7'h00, 7'h02, 0, 0, 1, 7'h01);
    add(0, 7'h02, 0, 0, 0, 1, 2'd0, 7'h00, 7'h02, 0, 0, 1, 7'h00); // 48 mask drop
    add(0, 7'h02, 0, 0, 0, 0, 2'd3, 7'h00, 7'h00, 1, 0, 1, 7'h00); // revoked
    add(0, 7'h02, 0, 0, 0, 1, 2'd0, 7'h7F, 7'h00, 1, 0, 1, 7'h7F);
    add(0, 7'h02, 0, 0, 0, 0, 2'd3, 7'h00, 7'h02, 0, 0, 1, 7'h01); // 51 WAIT_ACK
    add(1, 7'h02, 0, 0, 0, 0, 2'd1, 7'h00, 7'h00, 1, 0, 1, 7'h00); // 52 reset mid-op
    add(0, 7'h02, 0, 0, 0, 0, 2'd0, 7'h00, 7'h00, 1, 0, 1, 7'h00);
    add(0, 7'h02, 0, 0, 0, 0, 2'd2, 7'h00, 7'h00, 1, 0, 1, 7'h00);

    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].irq, tbl[k].sys, tbl[k].jmp, tbl[k].ert,
            tbl[k].we, tbl[k].addr, tbl[k].wd);
      tick();
      cmp($sformatf("step%0d int_vec", k), int_vec, tbl[k].vec);
      cmp($sformatf("step%0d int_en_n", k), {6'd0, int_en_n}, {6'd0, tbl[k].en_n});
      cmp($sformatf("step%0d in_service", k), {6'd0, in_service}, {6'd0, tbl[k].isv});
      if (tbl[k].chk) cmp($sformatf("step%0d csr_rdata", k), csr_rdata, tbl[k].rd);
    end

    // Hand sequence: one-cycle pulse on irq5, bounded wait for the request.
    drive(0, 7'h00, 0, 0, 0, 0, 2'd0, 7'h00);
    repeat (4) tick();
    drive(0, 7'h00, 0, 0, 0, 1, 2'd1, 7'h7F); tick();
    drive(0, 7'h00, 0, 0, 0, 1, 2'd0, 7'h7F); tick();
    drive(0, 7'h00, 0, 0, 0, 1, 2'd2, 7'h01); tick();
    drive(0, 7'h00, 0, 0, 0, 0, 2'd1, 7'h00); tick();
    cmp("pulse idle int_en_n", {6'd0, int_en_n}, 7'h01);
    cmp("pulse idle pending", csr_rdata, 7'h00);
    irq_in = 7'h20;
    lat = 0;
    do begin
      tick();
      irq_in = 7'h00;
      lat++;
    end while (int_en_n === 1'b1 && lat < 10);
    cmp("pulse latency", 7'(lat), 7'd4);
    cmp("pulse int_vec", int_vec, 7'h20);
    int_jump = 1'b1; tick(); int_jump = 1'b0;
    cmp("pulse ack in_service", {6'd0, in_service}, 7'h01);
    cmp("pulse ack pending", csr_rdata, 7'h00);
    eret = 1'b1; tick(); eret = 1'b0;
    cmp("pulse eret in_service", {6'd0, in_service}, 7'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
